usrt_rx_fifo: RTL and testbench
===============================

# usrt_rx_fifo

Parametrised synchronous USRT receiver that replaces the fixed 8-bit deserializer. It generates its own baud tick from `pClk`, deframes start/data/parity/stop, and checks the frame. Good words are queued in an internal FIFO with a valid/ready read port toward the AMBA-side register logic. Parity, framing and overrun errors are reported as one-cycle pulses.

## Interface
- `DATA_W`, 8: data bits per frame, 5..16.
- `DIV`, 80: `pClk` cycles per bit; must be at least 2.
- `DEPTH`, 4: FIFO entries; power of 2, at least 2.
- `ODD_PARITY`, 0: 0 means the parity bit is the XOR of the data bits; 1 means the inverted XOR. Used only with `USRT_PARITY_EN`.
- `pClk`, in, 1: single clock for the whole block.
- `pReset`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: receiver enable.
- `rx`, in, 1: serial line, idle 0, already synchronous to `pClk`.
- `out_ready`, in, 1: consumer accepts the head word.
- `out_valid`, out, 1: FIFO not empty.
- `out_data`, out, `DATA_W`: FIFO head word (show-ahead).
- `level`, out, `$clog2(DEPTH)+1`: FIFO occupancy.
- `parity_err`, out, 1: one-cycle pulse.
- `frame_err`, out, 1: one-cycle pulse.
- `overrun`, out, 1: one-cycle pulse.

## Operation
- Frame format, in line order: start bit 1, then `DATA_W` data bits LSB first, then the parity bit (only when `USRT_PARITY_EN` is defined), then stop bit 0.
- Baud counter:
  - Counts 0..`DIV`-1 while `en` is high and wraps to 0.
  - `tick` is asserted on the cycle where the count equals `DIV`-1.
  - When `en` is low, the counter is held at 0.
- FSM states are IDLE, DATA, PARITY and STOP. All transitions happen only on `tick` cycles, and `rx` is sampled on those same cycles.
  - IDLE: `rx`=1 → DATA with bit index 0. Otherwise stay in IDLE.
  - DATA: shift `rx` into bit[index]. At index `DATA_W`-1 go to PARITY, or to STOP if parity is compiled out.
  - PARITY: if `rx` does not equal the expected parity, pulse `parity_err` and go to IDLE (the word is dropped). Otherwise go to STOP.
  - STOP: `rx`=0 means the frame is good and the word is pushed. `rx`=1 pulses `frame_err` and drops the word; this 1 is not treated as a new start bit. Either way → IDLE.
- `en` low forces IDLE and clears the shift register and bit index on the next edge. A partial frame is discarded. FIFO contents are kept.
- FIFO behaviour:
  - Push of a good word when the FIFO is full and no pop happens that cycle: the word is dropped and `overrun` pulses. Existing contents are unchanged.
  - Push and pop in the same cycle while full: the push is accepted, `level` is unchanged, and there is no overrun.
  - Pop happens when `out_valid && out_ready`. `out_ready` has no effect when the FIFO is empty.
  - Read and write pointers wrap modulo `DEPTH`.

## Timing
- Reset values: FSM IDLE, counter 0, shift register 0, `level` 0, `out_valid` 0, `out_data` 0, all error pulses 0.
- Reset takes effect immediately when asserted and may arrive mid-frame.
- The first `tick` occurs `DIV` cycles after `en` rises.
- Push happens on the clock edge that ends the STOP `tick` cycle. `out_valid` and `level` update in the cycle after that; the word appears at `out_data` in the same cycle if the FIFO was empty.
- Error pulses are registered and high for exactly the one cycle after the offending `tick`.
- Latency from the start-bit `tick` to `out_valid` is (`DATA_W`+2)·`DIV`+1 cycles with parity, and (`DATA_W`+1)·`DIV`+1 cycles without parity.

## Configuration
- `USRT_PARITY_EN` defined: the PARITY state exists, the frame is `DATA_W`+3 bits, and `parity_err` is active.
- `USRT_PARITY_EN` not defined: the PARITY state is removed, the frame is `DATA_W`+2 bits, `parity_err` is tied to 0, and `ODD_PARITY` is ignored.

## Structure
- Shared package `usrt_pkg` holds:
  - the FSM state enum `rx_state_t`;
  - the `USRT_START_BIT`=1 and `USRT_STOP_BIT`=0 constants;
  - a parity function.
- Sub-module `usrt_sync_fifo` provides the FIFO, parametrised by `DATA_W` and `DEPTH`. It has push/pop/full/empty/level ports and the same clock and reset.
- The baud counter and the FSM live in the top level.

## Test plan
All scenarios use `DATA_W`=8, `DIV`=4, `DEPTH`=4 and `USRT_PARITY_EN` defined, unless noted.
1. Frame 0xA5: line bits 1, 1,0,1,0,0,1,0,1, parity 0, stop 0 → `out_data`=0xA5 and `level`=1 exactly 41 cycles after the start `tick`; no error pulses.
2. Data 0x01 sent with parity bit 0 → `parity_err` pulses once; `level` stays 0; the next good frame 0x3C is received correctly.
3. Frame 0x5A sent with stop bit 1 → `frame_err` pulses once, nothing is pushed, and the FSM returns to IDLE.
4. Five good frames 0x10..0x14 with `out_ready`=0 → `level`=4, `overrun` pulses on the fifth frame, `out_data`=0x10. Then popping four times yields 0x10..0x13 in order.
5. `en` dropped after 3 data bits, then a full 0x77 frame sent → only 0x77 is queued. Rerun without `USRT_PARITY_EN`: 0x77 is received using a 10-bit frame.
6. `pReset` asserted mid-frame with `level`=2 → all outputs are 0 immediately, and the first frame after release is received cleanly.

Source files
------------

// File: rtl/usrt_pkg.sv
// usrt_pkg: FSM state type, line-level frame constants and the parity helper
// shared by the USRT receiver and its FIFO.
package usrt_pkg;

    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    localparam logic USRT_START_BIT = 1'b1;
    localparam logic USRT_STOP_BIT  = 1'b0;
    localparam int   USRT_MAX_W     = 16;

    // Even parity is the plain XOR of the data; odd parity inverts it.
    // Bits above the real word width must be zero.
    function automatic logic usrt_parity(input logic [USRT_MAX_W-1:0] data,
                                         input logic                  odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/usrt_sync_fifo.sv
// usrt_sync_fifo: single-clock show-ahead FIFO with occupancy count. A push
// into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module usrt_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        data_i,
    input  logic                     pop_i,
    output logic [DATA_W-1:0]        data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       level_q, level_d;
    logic              do_push, do_pop;

    assign empty_o = (level_q == '0);
    assign full_o  = (level_q == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // NOTE: storage is left unreset; the head is masked to zero while empty,
    // so stale entries are never visible and the array maps onto plain RAM.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign level_o = level_q;

endmodule

// File: rtl/usrt_rx_fifo.sv
// usrt_rx_fifo: synchronous USRT receiver with internal baud tick, frame
// checking and a receive FIFO. Define USRT_PARITY_EN to add the parity bit.
module usrt_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DIV        = 80,
    parameter int DEPTH      = 4,
    parameter int ODD_PARITY = 0
) (
    input  logic                    pClk,
    input  logic                    pReset,
    input  logic                    en,
    input  logic                    rx,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [$clog2(DEPTH):0]  level,
    output logic                    parity_err,
    output logic                    frame_err,
    output logic                    overrun
);

    import usrt_pkg::*;

    localparam int CNT_W = $clog2(DIV);
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    if (DATA_W < 5 || DATA_W > USRT_MAX_W || DIV < 2 || DEPTH < 2 ||
        (DEPTH & (DEPTH - 1)) != 0 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
        $error("usrt_rx_fifo: illegal parameter combination");
    end

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick;
    rx_state_t         state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              frm_err_q, frm_err_d;
    logic              ovr_q, ovr_d;
    logic              push, pop, fifo_full, fifo_empty;

    assign tick = en && (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || tick) cnt_d = '0;
    end

`ifdef USRT_PARITY_EN
    logic                  par_err_q, par_err_d;
    logic [USRT_MAX_W-1:0] par_word;
    logic                  par_exp;

    always_comb begin
        par_word               = '0;
        par_word[DATA_W-1:0]   = shift_q;
    end
    assign par_exp = usrt_parity(par_word, ODD_PARITY != 0);
`endif

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        shift_d   = shift_q;
        push      = 1'b0;
        frm_err_d = 1'b0;
`ifdef USRT_PARITY_EN
        par_err_d = 1'b0;
`endif
        if (!en) begin
            // Disabling abandons any partial frame; the FIFO is untouched.
            state_d = RX_IDLE;
            idx_d   = '0;
            shift_d = '0;
        end else if (tick) begin
            case (state_q)
                RX_IDLE: begin
                    if (rx == USRT_START_BIT) begin
                        state_d = RX_DATA;
                        idx_d   = '0;
                    end
                end
                RX_DATA: begin
                    shift_d[idx_q] = rx;
                    if (idx_q == IDX_LAST) begin
`ifdef USRT_PARITY_EN
                        state_d = RX_PARITY;
`else
                        state_d = RX_STOP;
`endif
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
`ifdef USRT_PARITY_EN
                RX_PARITY: begin
                    if (rx != par_exp) begin
                        par_err_d = 1'b1;
                        state_d   = RX_IDLE;
                    end else begin
                        state_d   = RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    // A 1 here is a broken stop bit, never the next start bit.
                    if (rx == USRT_STOP_BIT) push      = 1'b1;
                    else                     frm_err_d = 1'b1;
                    state_d = RX_IDLE;
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    assign pop   = out_valid && out_ready;
    assign ovr_d = push && fifo_full && !pop;

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) begin
            cnt_q     <= '0;
            state_q   <= RX_IDLE;
            idx_q     <= '0;
            shift_q   <= '0;
            frm_err_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            idx_q     <= idx_d;
            shift_q   <= shift_d;
            frm_err_q <= frm_err_d;
            ovr_q     <= ovr_d;
        end
    end

`ifdef USRT_PARITY_EN
    always_ff @(posedge pClk or negedge pReset) begin
        if (!pReset) par_err_q <= 1'b0;
        else         par_err_q <= par_err_d;
    end
    assign parity_err = par_err_q;
`else
    assign parity_err = 1'b0;
`endif

    usrt_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (pClk),
        .rst_n_i (pReset),
        .push_i  (push),
        .data_i  (shift_q),
        .pop_i   (pop),
        .data_o  (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (level)
    );

    assign out_valid = !fifo_empty;
    assign frame_err = frm_err_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_usrt_rx_fifo.sv
// tb_usrt_rx_fifo: directed frames against a scoreboard queue and occupancy
// model; adapts frame length to whether USRT_PARITY_EN is defined.
module tb_usrt_rx_fifo;

    localparam int DATA_W = 8;
    localparam int DIV    = 4;
    localparam int DEPTH  = 4;
`ifdef USRT_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    logic              pClk      = 1'b0;
    logic              pReset    = 1'b0;
    logic              en        = 1'b0;
    logic              rx        = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [2:0]        level;
    logic              parity_err, frame_err, overrun;

    usrt_rx_fifo #(
        .DATA_W     (DATA_W),
        .DIV        (DIV),
        .DEPTH      (DEPTH),
        .ODD_PARITY (0)
    ) dut (
        .pClk       (pClk),
        .pReset     (pReset),
        .en         (en),
        .rx         (rx),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .level      (level),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 pClk = ~pClk;

    int checks = 0;
    int errors = 0;
    int n_par = 0, n_frm = 0, n_ovr = 0;
    int cyc = 0;
    int t_rise = -1;
    logic prev_valid = 1'b0;
    int phase = 0;
    logic [DATA_W-1:0] exp_q [$];
    int model_level = 0;

    always @(posedge pClk) cyc <= cyc + 1;

    // Pulse counters and out_valid rise time, sampled mid-cycle.
    always @(negedge pClk) begin
        if (parity_err === 1'b1) n_par <= n_par + 1;
        if (frame_err  === 1'b1) n_frm <= n_frm + 1;
        if (overrun    === 1'b1) n_ovr <= n_ovr + 1;
        if (out_valid === 1'b1 && prev_valid !== 1'b1) t_rise <= cyc;
        prev_valid <= out_valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge pClk);
        phase = (phase + 1) % DIV;
    endtask

    task automatic wait_aligned();
        while (phase != 0) step();
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        repeat (DIV) step();
    endtask

    task automatic send_frame(input logic [DATA_W-1:0] d, input logic par_flip,
                              input logic stop_val, output int t_start);
        wait_aligned();
        send_bit(1'b1);
        t_start = cyc;
        for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
`ifdef USRT_PARITY_EN
        send_bit((^d) ^ par_flip);
`endif
        send_bit(stop_val);
        rx = 1'b0;
    endtask

    task automatic rx_good(input logic [DATA_W-1:0] d);
        int t;
        int ovr0 = n_ovr;
        int frm0 = n_frm;
        int par0 = n_par;
        bit expect_ovr = (model_level == DEPTH);
        send_frame(d, 1'b0, 1'b0, t);
        if (!expect_ovr) begin
            exp_q.push_back(d);
            model_level++;
        end
        step();
        check("level_after_frame", 32'(level), model_level);
        check("overrun_pulses", n_ovr - ovr0, 32'(expect_ovr));
        check("no_frame_err", n_frm - frm0, 0);
        check("no_parity_err", n_par - par0, 0);
    endtask

    task automatic pop_check();
        check("pop_valid", 32'(out_valid), 1);
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 0, 1);
        end else begin
            check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
            out_ready = 1'b1;
            step();
            out_ready = 1'b0;
            model_level--;
            check("level_after_pop", 32'(level), model_level);
        end
    endtask

    initial begin
        int t0;
        int base;

        // Reset state
        step(); step();
        check("rst_valid", 32'(out_valid), 0);
        check("rst_data", 32'(out_data), 0);
        check("rst_level", 32'(level), 0);
        check("rst_pulses", 32'({parity_err, frame_err, overrun}), 0);
        pReset = 1'b1;
        en     = 1'b1;
        phase  = 0;

        // 1: frame 0xA5, latency from start tick to out_valid
        send_frame(8'hA5, 1'b0, 1'b0, t0);
        exp_q.push_back(8'hA5);
        model_level++;
        step();
        check("latency", t_rise + 1 - t0, (DATA_W + 1 + PAR_BITS) * DIV + 1);
        check("a5_level", 32'(level), 1);
        check("a5_errors", n_par + n_frm + n_ovr, 0);
        pop_check();

        // 2: bad parity dropped, then good frame 0x3C
`ifdef USRT_PARITY_EN
        base = n_par;
        send_frame(8'h01, 1'b1, 1'b0, t0);
        step();
        check("parity_pulse", n_par - base, 1);
        check("parity_level", 32'(level), 0);
`endif
        rx_good(8'h3C);
        pop_check();

        // 3: stop bit 1 -> frame error; the next frame directly follows
        base = n_frm;
        send_frame(8'h5A, 1'b0, 1'b1, t0);
        step();
        check("frame_pulse", n_frm - base, 1);
        check("frame_level", 32'(level), 0);
        rx_good(8'h66);
        pop_check();

        // 4: fill to DEPTH, fifth frame overruns
        for (int i = 0; i < 5; i++) rx_good(8'h10 + 8'(i));
        check("full_level", 32'(level), DEPTH);
        check("full_head", 32'(out_data), 32'h10);
        for (int i = 0; i < 4; i++) pop_check();
        check("drained_valid", 32'(out_valid), 0);

        // 5: en dropped after three data bits, then a full 0x77 frame
        wait_aligned();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        en = 1'b0;
        rx = 1'b0;
        repeat (3) step();
        en    = 1'b1;
        phase = 0;
        rx_good(8'h77);
        check("en_drop_level", 32'(level), 1);
        pop_check();

        // 6: asynchronous reset mid-frame with two words queued
        rx_good(8'h21);
        rx_good(8'h22);
        check("pre_reset_level", 32'(level), 2);
        wait_aligned();
        send_bit(1'b1);
        send_bit(1'b1);
        #2 pReset = 1'b0;
        rx = 1'b0;
        #1;
        check("async_rst_valid", 32'(out_valid), 0);
        check("async_rst_data", 32'(out_data), 0);
        check("async_rst_level", 32'(level), 0);
        check("async_rst_pulses", 32'({parity_err, frame_err, overrun}), 0);
        exp_q.delete();
        model_level = 0;
        step(); step();
        pReset = 1'b1;
        phase  = 0;
        rx_good(8'h99);
        pop_check();

        check("total_frame_err", n_frm, 1);
        check("total_parity_err", n_par, PAR_BITS);
        check("total_overrun", n_ovr, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
